// File: rtl/audio_volume_level.sv
// Turns the 12-bit microphone stream into a 0..15 paddle level: per-window
// peak deviation from mid-scale, quantised, with instant rise and one-step decay.
module audio_volume_level #(
    parameter int WINDOW = 4000,
    parameter int MID    = 2048,
    parameter int QSHIFT = 7
) (
    input  logic        clkAudio,
    input  logic        resetn,
    input  logic [11:0] mic_in,
    input  logic        freeze,
    output logic [3:0]  num,
    output logic [10:0] peak,
    output logic        level_valid
);

    localparam logic [15:0] LAST_CNT = 16'(WINDOW - 1);
    localparam logic [12:0] MID_CODE = 13'(MID);

    logic [15:0] cnt;
    logic [10:0] runMax;
    logic [12:0] micExt;
    logic [12:0] diff;
    logic [10:0] mag;
    logic [10:0] windowPeak;
    logic [10:0] shifted;
    logic [3:0]  rawLevel;
    logic        lastSample;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        micExt     = {1'b0, mic_in};
        diff       = '0;
        if (micExt >= MID_CODE) begin
            diff = micExt - MID_CODE;
        end else begin
            diff = MID_CODE - micExt;
        end
        // mic_in = 0 is one code further from mid-scale than full-scale is.
        mag        = (diff > 13'd2047) ? 11'd2047 : diff[10:0];
        lastSample = (cnt == LAST_CNT);
        windowPeak = (mag > runMax) ? mag : runMax;
        shifted    = windowPeak >> QSHIFT;
        rawLevel   = (shifted > 11'd15) ? 4'd15 : shifted[3:0];
    end

    always_ff @(posedge clkAudio or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            runMax      <= '0;
            peak        <= '0;
            num         <= '0;
            level_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            level_valid <= lastSample;
            if (lastSample) begin
                peak   <= windowPeak;
                runMax <= '0;
                cnt    <= '0;
                if (!freeze) begin
                    // raw < num implies num >= 1, so the decay cannot wrap.
                    num <= (rawLevel >= num) ? rawLevel : num - 4'd1;
                end
            end else begin
                runMax <= windowPeak;
                cnt    <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_volume_level.sv
// Scoreboard bench for audio_volume_level with WINDOW=8: stimulus queues the
// expected {peak,num} per window, a monitor checks each level_valid pulse.
module tb_audio_volume_level;

    localparam int WIN = 8;

    logic        clkAudio;
    logic        resetn;
    logic [11:0] mic_in;
    logic        freeze;
    logic [3:0]  num;
    logic [10:0] peak;
    logic        level_valid;

    int compared   = 0;
    int mismatched = 0;

    logic [14:0] expQ[$];

    audio_volume_level #(.WINDOW(WIN), .MID(2048), .QSHIFT(7)) dut (
        .clkAudio    (clkAudio),
        .resetn      (resetn),
        .mic_in      (mic_in),
        .freeze      (freeze),
        .num         (num),
        .peak        (peak),
        .level_valid (level_valid)
    );

    initial clkAudio = 1'b0;
    always #5 clkAudio = ~clkAudio;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every level_valid pulse must match the oldest queued expectation.
    always @(negedge clkAudio) begin
        if (resetn && level_valid) begin
            if (expQ.size() == 0) begin
                check("unexpected_level_valid", 16'd1, 16'd0);
            end else begin
                logic [14:0] e;
                e = expQ.pop_front();
                check("peak", {5'd0, peak}, {5'd0, e[14:4]});
                check("num", {12'd0, num}, {12'd0, e[3:0]});
            end
        end
    end

    // One full window of mid-scale samples with a single hot sample at hotIdx
    // (hotIdx outside 0..WIN-1 means no hot sample). The expectation is queued
    // just before the last sample so an early pulse finds an empty queue.
    task automatic run_window(input int hotIdx, input logic [11:0] hotVal, input logic frz,
                              input logic [10:0] expPeak, input logic [3:0] expNum);
        for (int i = 0; i < WIN; i++) begin
            mic_in = (i == hotIdx) ? hotVal : 12'd2048;
            freeze = frz;
            if (i == WIN - 1) expQ.push_back({expPeak, expNum});
            @(posedge clkAudio);
            #1;
        end
    endtask

    initial begin
        int waitCycles;
        resetn = 1'b0;
        mic_in = 12'd2048;
        freeze = 1'b0;

        // Reset held with a toggling mic input.
        for (int i = 0; i < 4; i++) begin
            mic_in = (i % 2 == 0) ? 12'd4095 : 12'd0;
            @(posedge clkAudio);
            #1;
        end
        check("reset_num", {12'd0, num}, 16'd0);
        check("reset_peak", {5'd0, peak}, 16'd0);
        check("reset_level_valid", {15'd0, level_valid}, 16'd0);
        resetn = 1'b1;

        // Silent first window.
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd0);
        check("pulse_after_window", {15'd0, level_valid}, 16'd1);

        // Instant rise, then one-step decay per silent window.
        run_window(3, 12'd4095, 1'b0, 11'd2047, 4'd15);
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd14);
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd13);
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd12);

        // Below-mid samples: 1000 -> 1048 (raw 8 < 12, decay to 11); 0 saturates.
        run_window(5, 12'd1000, 1'b0, 11'd1048, 4'd11);
        run_window(2, 12'd0, 1'b0, 11'd2047, 4'd15);

        // Last sample of a window, then first sample of the next (raw 7).
        run_window(7, 12'd3000, 1'b0, 11'd952, 4'd14);
        run_window(0, 12'd3000, 1'b0, 11'd952, 4'd13);

        // Decay to 10, then freeze through a full-scale window.
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd12);
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd11);
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd10);
        run_window(4, 12'd4095, 1'b1, 11'd2047, 4'd10);
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd9);

        // Partial window with a loud sample, discarded by a mid-window reset.
        for (int i = 0; i < 5; i++) begin
            mic_in = (i == 1) ? 12'd4095 : 12'd2048;
            @(posedge clkAudio);
            #1;
        end
        resetn = 1'b0;
        #1;
        check("midreset_num", {12'd0, num}, 16'd0);
        check("midreset_peak", {5'd0, peak}, 16'd0);
        @(posedge clkAudio);
        #1;
        resetn = 1'b1;
        run_window(-1, 12'd2048, 1'b0, 11'd0, 4'd0);

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 20) begin
            @(posedge clkAudio);
            waitCycles++;
        end
        @(posedge clkAudio);
        #1;
        check("queue_drained", 16'(expQ.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
